// File: rtl/xgmii_tx_arbiter.sv
// Round-robin arbiter for four requesters sharing one XGMII TX port, with an
// enforced inter-frame gap and a grant-length watchdog.
module xgmii_tx_arbiter #(
  parameter int IFG_CYCLES       = 2,
  parameter int MAX_FRAME_CYCLES = 1200
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  req,
  input  logic [3:0]  done,
  input  logic        link_up,
  output logic [3:0]  gnt,
  output logic [1:0]  active_port,
  output logic        busy,
  output logic        timeout_pulse,
  output logic [15:0] timeout_cnt
);
  // state | meaning
  // IDLE  | no grant; arbitrate when link is up and any req is set
  // GRANT | gnt one-hot to active_port until its done or watchdog expiry
  // IFG   | gnt held low for IFG_CYCLES, then back to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    IFG   = 2'd2
  } state_t;

  localparam int CW = $clog2(MAX_FRAME_CYCLES + 1);
  localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_MAX  = CW'(MAX_FRAME_CYCLES);
  localparam logic [IW-1:0] IFG_LOAD = (IFG_CYCLES > 0) ? IW'(IFG_CYCLES - 1) : '0;
  localparam state_t        REL_STATE = (IFG_CYCLES > 0) ? IFG : IDLE;

  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    ap_q, ap_d;
  logic          busy_q, busy_d;
  logic          pulse_q, pulse_d;
  logic [15:0]   tcnt_q, tcnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [IW-1:0] ifg_q, ifg_d;

  logic [1:0]    pick;
  logic [1:0]    cand;
  logic          found;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    ap_d    = ap_q;
    pulse_d = 1'b0;
    tcnt_d  = tcnt_q;
    cyc_d   = cyc_q;
    ifg_d   = ifg_q;
    pick    = ptr_q;
    cand    = ptr_q;
    found   = 1'b0;

    // first set request at or above the round-robin pointer, wrapping
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (link_up && found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick;
          ap_d    = pick;
          ptr_d   = pick + 2'd1;
          cyc_d   = CW'(1);
        end
      end
      GRANT: begin
        if (done[ap_q] || (cyc_q == CYC_MAX)) begin
          state_d = REL_STATE;
          gnt_d   = '0;
          cyc_d   = '0;
          ifg_d   = IFG_LOAD;
          // a done landing on the final allowed cycle is a normal release
          if (!done[ap_q]) begin
            pulse_d = 1'b1;
            if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      IFG: begin
        if (ifg_q == '0) state_d = IDLE;
        else             ifg_d   = ifg_q - IW'(1);
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      ap_q    <= '0;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
      tcnt_q  <= '0;
      cyc_q   <= '0;
      ifg_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      ap_q    <= ap_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
      tcnt_q  <= tcnt_d;
      cyc_q   <= cyc_d;
      ifg_q   <= ifg_d;
    end
  end

  assign gnt           = gnt_q;
  assign active_port   = ap_q;
  assign busy          = busy_q;
  assign timeout_pulse = pulse_q;
  assign timeout_cnt   = tcnt_q;
endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// Directed bench for xgmii_tx_arbiter: a timestamp-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_xgmii_tx_arbiter;
  localparam int IFG  = 2;
  localparam int MAXC = 1200;

  logic clk = 1'b0;
  logic clk_f = 1'b0;
  always #3 clk = ~clk;
  always #1 clk_f = ~clk_f;

  logic        rst, link_up;
  logic [3:0]  req, done;
  logic [3:0]  gnt;
  logic [1:0]  active_port;
  logic        busy, timeout_pulse;
  logic [15:0] timeout_cnt;

  logic        rst_s, link_s;
  logic [3:0]  req_s, done_s;
  logic [3:0]  gnt_s;
  logic [1:0]  ap_s;
  logic        busy_s, tp_s;
  logic [15:0] tcnt_s;

  xgmii_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_FRAME_CYCLES(MAXC)) dut (
    .sys_clk(clk), .sys_rst(rst), .req(req), .done(done), .link_up(link_up),
    .gnt(gnt), .active_port(active_port), .busy(busy),
    .timeout_pulse(timeout_pulse), .timeout_cnt(timeout_cnt)
  );

  // no gap and a one-cycle watchdog: a timeout every second cycle
  xgmii_tx_arbiter #(.IFG_CYCLES(0), .MAX_FRAME_CYCLES(1)) dut_sat (
    .sys_clk(clk_f), .sys_rst(rst_s), .req(req_s), .done(done_s), .link_up(link_s),
    .gnt(gnt_s), .active_port(ap_s), .busy(busy_s),
    .timeout_pulse(tp_s), .timeout_cnt(tcnt_s)
  );

  int vec_cnt = 0;
  int miss_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // model: owner of the port, its grant length, and the first cycle at which
  // arbitration is permitted again after a release
  int         cyc = 0;
  int         m_owner = -1;
  int         m_len = 0;
  int         m_next_ok = 0;
  int         m_ptr = 0;
  logic [1:0] m_ap = 2'd0;
  int         m_tcnt = 0;
  logic       m_tp = 1'b0;

  function automatic void model_step();
    int  c;
    bit  found;
    c     = cyc;
    m_tp  = 1'b0;
    found = 1'b0;
    if (rst) begin
      m_owner = -1; m_len = 0; m_next_ok = 0; m_ptr = 0; m_ap = 2'd0; m_tcnt = 0;
    end else if (m_owner >= 0) begin
      if (done[m_owner]) begin
        m_owner = -1; m_next_ok = c + 1 + IFG;
      end else if (m_len == MAXC) begin
        m_owner = -1; m_next_ok = c + 1 + IFG; m_tp = 1'b1;
        if (m_tcnt < 65535) m_tcnt++;
      end else begin
        m_len++;
      end
    end else if (c >= m_next_ok && link_up && req != 4'b0) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (!found && req[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_ap    = 2'(idx);
          m_ptr   = (idx + 1) % 4;
          m_len   = 1;
        end
      end
    end
    cyc = c + 1;
  endfunction

  task automatic compare_outputs();
    logic [3:0] e_gnt;
    e_gnt = 4'b0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    check("cyc_gnt", gnt, e_gnt);
    check("cyc_active_port", active_port, m_ap);
    check("cyc_busy", busy, (m_owner >= 0) || (cyc < m_next_ok));
    check("cyc_timeout_pulse", timeout_pulse, m_tp);
    check("cyc_timeout_cnt", timeout_cnt, m_tcnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic wait_gnt(input string name, input logic [3:0] exp);
    int guard;
    guard = 0;
    while (gnt == 4'b0 && guard < 20) begin
      tick();
      guard++;
    end
    check(name, gnt, exp);
  endtask

  initial begin
    int n;
    rst = 1'b1; req = 4'b0; done = 4'b0; link_up = 1'b0;
    rst_s = 1'b1; req_s = 4'b0001; done_s = 4'b0; link_s = 1'b1;

    repeat (3) tick();
    check("rst_gnt", gnt, 4'b0);
    check("rst_active_port", active_port, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout_cnt", timeout_cnt, 16'h0);
    rst = 1'b0;
    tick();

    // round robin with all requesting, each grantee done in its 3rd cycle
    begin : rr
      logic [3:0] seq[$];
      int         gaps[$];
      logic [3:0] exp_seq[5];
      int         gcnt, zc, guard;
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      gcnt = 0; zc = 0; guard = 0;
      link_up = 1'b1; req = 4'b1111;
      while (!(seq.size() == 5 && gnt == 4'b0) && guard < 100) begin
        tick();
        guard++;
        if (gnt != 4'b0) begin
          if (gcnt == 0) begin
            seq.push_back(gnt);
            if (seq.size() > 1) gaps.push_back(zc);
          end
          gcnt++;
          zc = 0;
        end else begin
          gcnt = 0;
          zc++;
        end
        done = (gcnt == 3) ? gnt : 4'b0;
      end
      req = 4'b0;
      check("rr_grant_count", seq.size(), 5);
      for (int i = 0; i < seq.size() && i < 5; i++) check("rr_sequence", seq[i], exp_seq[i]);
      check("rr_gap_count", gaps.size(), 4);
      foreach (gaps[i]) check("rr_gap_len", gaps[i], 3);
    end

    // link down holds off the grant; grant one cycle after link returns
    link_up = 1'b0; req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("linkdown_gnt", gnt, 4'b0);
    end
    link_up = 1'b1;
    tick();
    check("linkup_gnt", gnt, 4'b0100);
    check("linkup_active_port", active_port, 2'd2);
    done = 4'b0100;
    tick();
    done = 4'b0; req = 4'b0;
    check("linkup_release", gnt, 4'b0);

    // foreign done ignored; release only on the grantee's done
    req = 4'b0001;
    wait_gnt("foreign_grant", 4'b0001);
    done = 4'b1000;
    for (int i = 1; i <= 5; i++) begin
      tick();
      done = 4'b0;
      check("foreign_hold", gnt, 4'b0001);
    end
    done = 4'b0001; req = 4'b0;
    tick();
    done = 4'b0;
    check("foreign_release", gnt, 4'b0);

    // watchdog: grantee 1 never finishes
    req = 4'b0010;
    wait_gnt("wd_grant", 4'b0010);
    n = 1;
    while (gnt != 4'b0 && n < 1300) begin
      tick();
      if (gnt != 4'b0) n++;
    end
    req = 4'b0;
    check("wd_grant_len", n, 1200);
    check("wd_pulse", timeout_pulse, 1'b1);
    check("wd_count", timeout_cnt, 16'd1);
    tick();
    check("wd_pulse_width", timeout_pulse, 1'b0);

    // reset in the 4th cycle of a grant to port 2
    req = 4'b1111;
    wait_gnt("rst_grant", 4'b0100);
    repeat (3) tick();
    check("rst_pre_gnt", gnt, 4'b0100);
    rst = 1'b1;
    tick();
    check("rst_mid_gnt", gnt, 4'b0);
    check("rst_mid_count", timeout_cnt, 16'd0);
    check("rst_mid_busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    check("rst_first_grant", gnt, 4'b0001);

    // done arriving in the final watchdog cycle is a normal release
    n = 1;
    while (n < 1200) begin
      tick();
      n++;
    end
    check("coinc_hold", gnt, 4'b0001);
    done = 4'b0001; req = 4'b0;
    tick();
    done = 4'b0;
    check("coinc_gnt", gnt, 4'b0);
    check("coinc_pulse", timeout_pulse, 1'b0);
    check("coinc_count", timeout_cnt, 16'd0);
    repeat (4) tick();

    // saturation of the timeout counter
    begin : sat
      int np, guard;
      logic [31:0] e_cnt;
      np = 0; guard = 0;
      @(negedge clk_f);
      rst_s = 1'b0;
      while (np < 65536 && guard < 140000) begin
        @(negedge clk_f);
        guard++;
        if (tp_s) begin
          np++;
          e_cnt = (np > 65535) ? 32'd65535 : 32'(np);
          check("sat_count", tcnt_s, e_cnt);
          check("sat_gnt", gnt_s, 4'b0);
          check("sat_busy", busy_s, 1'b0);
          check("sat_active_port", ap_s, 2'd0);
        end
      end
      check("sat_pulses", np, 65536);
      check("sat_final", tcnt_s, 16'hFFFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
